// File: rtl/str_pkg.sv
// Shared types and constants for the upper-casing character FIFO.
package str_pkg;

    localparam int CHAR_W = 8;

    localparam logic [CHAR_W-1:0] LOWER_A     = 8'h61;
    localparam logic [CHAR_W-1:0] LOWER_Z     = 8'h7A;
    localparam logic [CHAR_W-1:0] CASE_OFFSET = 8'h20;

    typedef enum logic {
        IDLE,
        BODY
    } len_state_t;

    typedef struct packed {
        logic              last;
        logic [CHAR_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/str_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO: head entry is always visible on rd_data_o.
module str_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en_i,
    input  logic [W-1:0]           wr_data_i,
    input  logic                   rd_en_i,
    output logic [W-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push, pop;

    assign push = wr_en_i && (level_q != FULL_LVL);
    assign pop  = rd_en_i && (level_q != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

endmodule

// File: rtl/str_case_fifo.sv
// Upper-cases incoming ASCII characters into a FWFT FIFO and reports the length
// of each input string as it completes, independent of output back-pressure.
module str_case_fifo
    import str_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LEN_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CHAR_W-1:0]      in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHAR_W-1:0]      out_data,
    output logic                   out_last,
    output logic                   len_valid,
    output logic [LEN_W-1:0]       len_data,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    function automatic logic [CHAR_W-1:0] to_upper(input logic [CHAR_W-1:0] c);
        if (c >= LOWER_A && c <= LOWER_Z) return c - CASE_OFFSET;
        return c;
    endfunction

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    fifo_entry_t wr_entry, rd_entry;
    logic        accept;

    assign in_ready      = (level < FULL_LVL);
    assign accept        = in_valid && in_ready;
    assign wr_entry.last = in_last;
    assign wr_entry.data = to_upper(in_data);

    str_sync_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fifo_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (accept),
        .wr_data_i (wr_entry),
        .rd_en_i   (out_ready),
        .rd_data_o (rd_entry),
        .level_o   (level)
    );

    assign out_valid = (level != '0);
    assign out_data  = rd_entry.data;
    assign out_last  = rd_entry.last;

    len_state_t       state_q;
    logic [LEN_W-1:0] count_q;
    logic             len_valid_q;
    logic [LEN_W-1:0] len_data_q;

    // Length tracker: counts accepted characters, saturating rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            len_valid_q <= 1'b0;
            len_data_q  <= '0;
        end else begin
            len_valid_q <= 1'b0;
            if (accept) begin
                case (state_q)
                    IDLE: begin
                        if (in_last) begin
                            len_valid_q <= 1'b1;
                            len_data_q  <= LEN_W'(1);
                        end else begin
                            state_q <= BODY;
                            count_q <= LEN_W'(1);
                        end
                    end
                    BODY: begin
                        if (in_last) begin
                            len_valid_q <= 1'b1;
                            len_data_q  <= sat_inc(count_q);
                            count_q     <= '0;
                            state_q     <= IDLE;
                        end else begin
                            count_q <= sat_inc(count_q);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign len_valid = len_valid_q;
    assign len_data  = len_data_q;

endmodule
